// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/32-scan sequencer: shifts one row of pixel pairs out of the frame
// buffer, blanks, latches the row address, then shows the row for a fixed
// window with NOE gated low for `brightness` cycles.
module hub75_scan_ctrl #(
    parameter int COLS         = 64,
    parameter int ROW_BITS     = 5,
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int WIN_CYCLES   = 256,
    localparam int COL_BITS    = $clog2(COLS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [7:0]                   brightness,
    output logic                         fb_rd,
    output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
    input  logic [5:0]                   fb_rdata,
    output logic                         LP_CLK,
    output logic                         LATCH,
    output logic                         NOE,
    output logic [ROW_BITS-1:0]          ROW,
    output logic [2:0]                   RGB0,
    output logic [2:0]                   RGB1,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int SLOT  = 1 + 2*CLK_DIV;
    localparam int M1    = (SLOT > BLANK_CYCLES) ? SLOT : BLANK_CYCLES;
    localparam int M2    = (M1 > LATCH_CYCLES) ? M1 : LATCH_CYCLES;
    localparam int MAXC  = (M2 > WIN_CYCLES) ? M2 : WIN_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [ROW_BITS-1:0]  row_cnt, row_nx;
    logic [COL_BITS-1:0]  col_cnt, col_nx;
    logic [ROW_BITS-1:0]  row_q;
    logic [5:0]           rgb_q;
    logic [5:0]           rgb;
    logic [7:0]           bright_q;
    logic                 win_end;

    assign win_end = (state == S_DISPLAY) && (cnt == CNT_W'(WIN_CYCLES - 1));

    // State, phase counter and row/column position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            row_cnt <= row_nx;
            col_cnt <= col_nx;
        end
    end

    // Next-state: every state is a counted phase; cnt restarts on each transition
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        row_nx   = row_cnt;
        col_nx   = col_cnt;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (enable) begin
                    state_nx = S_SHIFT;
                    row_nx   = '0;
                    col_nx   = '0;
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_W'(SLOT - 1)) begin
                    cnt_nx = '0;
                    if (col_cnt == COL_BITS'(COLS - 1)) begin
                        state_nx = S_BLANK;
                        col_nx   = '0;
                    end else begin
                        col_nx = col_cnt + COL_BITS'(1);
                    end
                end
            end
            S_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_DISPLAY;
                end
            end
            S_DISPLAY: begin
                if (win_end) begin
                    cnt_nx = '0;
                    col_nx = '0;
                    row_nx = row_cnt + ROW_BITS'(1);
                    if (&row_cnt) state_nx = enable ? S_SHIFT : S_IDLE;
                    else          state_nx = S_SHIFT;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Panel-side registers: row address on LATCH entry, brightness on DISPLAY
    // entry, pixel data captured from the read port and cleared when leaving SHIFT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            rgb_q    <= '0;
            bright_q <= '0;
        end else begin
            if (state == S_BLANK && state_nx == S_LATCH)     row_q    <= row_cnt;
            if (state == S_LATCH && state_nx == S_DISPLAY)   bright_q <= brightness;
            if (state_nx != S_SHIFT)                         rgb_q    <= '0;
            else if (state == S_SHIFT && cnt == CNT_W'(1))   rgb_q    <= fb_rdata;
        end
    end

    // Read data is shown straight through in slot cycle 1 so the pixel is
    // stable for the full LP_CLK low phase; the register holds it afterwards.
    always_comb begin
        rgb = rgb_q;
        if (state == S_SHIFT && cnt == CNT_W'(1)) rgb = fb_rdata;
    end

    assign RGB0       = rgb[2:0];
    assign RGB1       = rgb[5:3];
    assign ROW        = row_q;
    assign fb_rd      = (state == S_SHIFT) && (cnt == '0);
    assign fb_addr    = {row_cnt, col_cnt};
    assign LP_CLK     = (state == S_SHIFT) && (cnt > CNT_W'(CLK_DIV));
    assign LATCH      = (state == S_LATCH);
    assign NOE        = !((state == S_DISPLAY) && (CNT_W'(bright_q) > cnt));
    assign busy       = (state != S_IDLE);
    assign frame_done = win_end && (&row_cnt);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: a negedge monitor records panel events
// and checks protocol invariants; one task per scenario checks the records.
module tb_hub75_scan_ctrl;

    localparam int CLK_DIV    = 2;
    localparam int ROW_PERIOD = 582;
    localparam int FRAME      = 18624;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [7:0]  brightness = 8'd0;
    logic        fb_rd;
    logic [10:0] fb_addr;
    logic [5:0]  fb_rdata = '0;
    logic        LP_CLK, LATCH, NOE, busy, frame_done;
    logic [4:0]  ROW;
    logic [2:0]  RGB0, RGB1;

    int errors = 0, checks = 0;

    hub75_scan_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .ROW(ROW),
        .RGB0(RGB0), .RGB1(RGB1), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Frame buffer model: one-cycle read latency, data = column index
    always @(posedge clk) if (fb_rd) fb_rdata <= fb_addr[5:0];

    // Event recorder + invariant checks, sampled on the falling edge
    int cyc = 0, run = 0, stable = 0;
    int rise_q[$], fbrd_cyc[$], latch_row[$], latch_cyc[$];
    int noe_run[$], noe_start[$], fd_cyc[$];
    logic       p_lp = 0, p_latch = 0, p_noe = 1;
    logic [5:0] p_rgb = '0;
    logic [4:0] p_row = '0;

    always @(negedge clk) begin
        cyc++;
        checks++;
        if (LATCH && !NOE) begin
            errors++; $display("FAIL latch_noe_overlap cyc=%0d LATCH=%b NOE=%b", cyc, LATCH, NOE);
        end
        checks++;
        if (LP_CLK && (!busy || LATCH || !NOE)) begin
            errors++; $display("FAIL lp_clk_outside_shift cyc=%0d busy=%b LATCH=%b NOE=%b", cyc, busy, LATCH, NOE);
        end
        checks++;
        if (ROW !== p_row && !(LATCH && !p_latch) && !rst) begin
            errors++; $display("FAIL row_change cyc=%0d got=%0d was=%0d", cyc, ROW, p_row);
        end
        if ({RGB1, RGB0} == p_rgb) stable++; else stable = 1;
        if (LP_CLK && !p_lp) begin
            rise_q.push_back(int'({RGB1, RGB0}));
            checks++;
            if (stable < CLK_DIV + 1) begin
                errors++; $display("FAIL rgb_setup cyc=%0d stable=%0d need=%0d", cyc, stable, CLK_DIV + 1);
            end
        end
        if (fb_rd) fbrd_cyc.push_back(cyc);
        if (LATCH && !p_latch) begin
            latch_row.push_back(int'(ROW));
            latch_cyc.push_back(cyc);
        end
        if (!NOE) begin
            if (p_noe) noe_start.push_back(cyc);
            run++;
        end else if (run > 0) begin
            noe_run.push_back(run);
            run = 0;
        end
        if (frame_done) fd_cyc.push_back(cyc);
        p_lp = LP_CLK; p_latch = LATCH; p_noe = NOE; p_rgb = {RGB1, RGB0}; p_row = ROW;
    end

    task automatic clear_q();
        rise_q.delete(); fbrd_cyc.delete(); latch_row.delete(); latch_cyc.delete();
        noe_run.delete(); noe_start.delete(); fd_cyc.delete(); run = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_q();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [27:0] obs;
        logic [27:0] exp_v;
        bit seen;
        exp_v = {1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 3'd0, 1'b0, 11'd0, 1'b0, 1'b0};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        obs = {LP_CLK, LATCH, NOE, ROW, RGB0, RGB1, fb_rd, fb_addr, busy, frame_done};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_initial got=%h exp=%h", obs, exp_v); end
        rst = 1'b0; enable = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ROW !== 5'd1) begin
            errors++; $display("FAIL running_before_reset busy=%b ROW=%0d exp busy=1 ROW=1", busy, ROW);
        end
        #3 rst = 1'b1;
        #1;
        obs = {LP_CLK, LATCH, NOE, ROW, RGB0, RGB1, fb_rd, fb_addr, busy, frame_done};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_midrun got=%h exp=%h", obs, exp_v); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fb_rd) seen = 1;
        end
        checks++;
        if (!seen || fb_addr !== 11'd0) begin
            errors++; $display("FAIL first_addr_after_reset seen=%0d addr=%0d exp=0", seen, fb_addr);
        end
        enable = 1'b0;
    endtask

    task automatic test_row_shift();
        int bad, bad_gap;
        do_reset();
        brightness = 8'd0; enable = 1'b1;
        for (int i = 0; i < 1000 && latch_row.size() < 1; i++) @(negedge clk);
        checks++;
        if (latch_row.size() < 1) begin errors++; $display("FAIL row_shift_timeout latches=%0d exp>=1", latch_row.size()); end
        checks++;
        if (rise_q.size() != 64) begin errors++; $display("FAIL lp_rise_count got=%0d exp=64", rise_q.size()); end
        bad = 0;
        for (int k = 0; k < rise_q.size() && k < 64; k++) if (rise_q[k] != k) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rise_data bad=%0d exp=0", bad); end
        checks++;
        if (fbrd_cyc.size() != 64) begin errors++; $display("FAIL fb_rd_count got=%0d exp=64", fbrd_cyc.size()); end
        bad_gap = 0;
        for (int k = 1; k < fbrd_cyc.size(); k++) if (fbrd_cyc[k] - fbrd_cyc[k-1] != 5) bad_gap++;
        checks++;
        if (bad_gap != 0) begin errors++; $display("FAIL fb_rd_spacing bad=%0d exp=0", bad_gap); end
        checks++;
        if (latch_row[0] != 0 || latch_cyc[0] - fbrd_cyc[0] != 324) begin
            errors++; $display("FAIL first_latch row=%0d offset=%0d exp row=0 offset=324",
                               latch_row[0], latch_cyc[0] - fbrd_cyc[0]);
        end
        enable = 1'b0;
    endtask

    task automatic test_scan_order();
        int bad_row, bad_per;
        do_reset();
        brightness = 8'd0; enable = 1'b1;
        for (int i = 0; i < 40000 && fd_cyc.size() < 2; i++) @(negedge clk);
        checks++;
        if (fd_cyc.size() != 2) begin errors++; $display("FAIL frame_done_count got=%0d exp=2", fd_cyc.size()); end
        checks++;
        if (fd_cyc[1] - fd_cyc[0] != FRAME) begin
            errors++; $display("FAIL frame_period got=%0d exp=%0d", fd_cyc[1] - fd_cyc[0], FRAME);
        end
        bad_row = 0; bad_per = 0;
        for (int k = 0; k < 33 && k < latch_row.size(); k++) if (latch_row[k] != k % 32) bad_row++;
        for (int k = 1; k < 33 && k < latch_cyc.size(); k++) if (latch_cyc[k] - latch_cyc[k-1] != ROW_PERIOD) bad_per++;
        checks++;
        if (latch_row.size() < 33 || bad_row != 0) begin
            errors++; $display("FAIL row_sequence latches=%0d bad=%0d exp latches>=33 bad=0", latch_row.size(), bad_row);
        end
        checks++;
        if (bad_per != 0) begin errors++; $display("FAIL row_period bad=%0d exp=0", bad_per); end
        checks++;
        if (fd_cyc[0] - latch_cyc[31] != 257) begin
            errors++; $display("FAIL frame_done_pos got=%0d exp=257", fd_cyc[0] - latch_cyc[31]);
        end
        checks++;
        if (noe_start.size() != 0) begin errors++; $display("FAIL noe_zero_brightness lows=%0d exp=0", noe_start.size()); end
        enable = 1'b0;
    endtask

    task automatic test_brightness();
        do_reset();
        brightness = 8'd128; enable = 1'b1;
        for (int i = 0; i < 1000 && noe_start.size() < 1; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        brightness = 8'd10;
        for (int i = 0; i < 2000 && latch_row.size() < 3; i++) @(negedge clk);
        checks++;
        if (noe_run.size() != 2) begin errors++; $display("FAIL noe_run_count got=%0d exp=2", noe_run.size()); end
        checks++;
        if (noe_run[0] != 128) begin errors++; $display("FAIL noe_len_row0 got=%0d exp=128", noe_run[0]); end
        checks++;
        if (noe_run[1] != 10) begin errors++; $display("FAIL noe_len_row1 got=%0d exp=10", noe_run[1]); end
        checks++;
        if (noe_start[0] - latch_cyc[0] != 2 || noe_start[1] - latch_cyc[1] != 2) begin
            errors++; $display("FAIL noe_start_offset got=%0d,%0d exp=2,2",
                               noe_start[0] - latch_cyc[0], noe_start[1] - latch_cyc[1]);
        end
        enable = 1'b0;
    endtask

    task automatic test_stop_boundary();
        int bad, n_rd;
        do_reset();
        brightness = 8'd4; enable = 1'b1;
        for (int i = 0; i < 9000 && latch_row.size() < 13; i++) @(negedge clk);
        checks++;
        if (latch_row[12] != 12) begin errors++; $display("FAIL stop_row12 got=%0d exp=12", latch_row[12]); end
        enable = 1'b0;
        for (int i = 0; i < 12000 && fd_cyc.size() < 1; i++) @(negedge clk);
        checks++;
        if (fd_cyc.size() != 1) begin errors++; $display("FAIL stop_frame_done got=%0d exp=1", fd_cyc.size()); end
        checks++;
        if (latch_row.size() != 32 || latch_row[31] != 31) begin
            errors++; $display("FAIL stop_rows latches=%0d last=%0d exp 32/31", latch_row.size(), latch_row[31]);
        end
        bad = 0;
        foreach (noe_run[k]) if (noe_run[k] != 4) bad++;
        checks++;
        if (noe_run.size() != 32 || bad != 0) begin
            errors++; $display("FAIL stop_display rows=%0d bad=%0d exp 32/0", noe_run.size(), bad);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || NOE !== 1'b1) begin
            errors++; $display("FAIL stop_idle busy=%b NOE=%b exp busy=0 NOE=1", busy, NOE);
        end
        n_rd = fbrd_cyc.size();
        repeat (600) @(negedge clk);
        checks++;
        if (fbrd_cyc.size() != n_rd || busy !== 1'b0) begin
            errors++; $display("FAIL stop_quiet reads=%0d exp=%0d busy=%b", fbrd_cyc.size() - n_rd, 0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_row_shift();
        test_scan_order();
        test_brightness();
        test_stop_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
Scan sequencer for the 64x64 HUB75 LED matrix in the temperature display path. It walks a 1/32-scan row/column schedule and fetches pixel pairs from the frame buffer through a fixed-latency read port. It shifts each row out on RGB0/RGB1 with LP_CLK, then blanks, latches and drives the row address. It controls brightness by gating NOE within a fixed display window per row.

Parameters:
COLS, 64, columns shifted per row (power of 2); COL_BITS = log2(COLS)
ROW_BITS, 5, row address width; 2**ROW_BITS scan rows
CLK_DIV, 2, LP_CLK low and high phase length in clk cycles (>=1)
BLANK_CYCLES, 4, NOE-high settle cycles after the last column
LATCH_CYCLES, 2, LATCH pulse width in clk cycles
WIN_CYCLES, 256, DISPLAY window length in clk cycles (>255)

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  asynchronous, active-high reset
enable  in  1  start scanning and keep scanning; sampled at frame boundaries
brightness  in  8  NOE-low cycles per row; sampled on DISPLAY entry
fb_rd  out  1  frame-buffer read strobe
fb_addr  out  ROW_BITS+COL_BITS  {row, col} read address
fb_rdata  in  6  {RGB1, RGB0}; valid the cycle after fb_rd
LP_CLK  out  1  panel shift clock
LATCH  out  1  panel latch
NOE  out  1  panel output enable, active low
ROW  out  ROW_BITS  panel row address
RGB0  out  3  upper-half pixel
RGB1  out  3  lower-half pixel
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at the end of the last row's DISPLAY

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset applies immediately, including mid-operation, and returns to IDLE with the row and column counters at 0.
- Reset values: LP_CLK=0, LATCH=0, NOE=1, ROW=0, RGB0=0, RGB1=0, fb_rd=0, fb_addr=0, busy=0, frame_done=0.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: NOE=1. If enable=1, the next cycle enters SHIFT with row=0, col=0.
- SHIFT: each column slot is 1+2*CLK_DIV cycles and NOE=1 throughout.
  - Slot cycle 0: fb_rd=1, fb_addr={row,col}.
  - Slot cycle 1: RGB1/RGB0 <= fb_rdata. They hold for the rest of the slot.
  - LP_CLK=0 for slot cycles 1..CLK_DIV and 1 for cycles CLK_DIV+1..2*CLK_DIV. This gives exactly one rising edge per column, with data stable for CLK_DIV cycles before the edge.
  - fb_rd=0 outside slot cycle 0.
  - After col=COLS-1, the controller goes to BLANK.
- BLANK: NOE=1, LP_CLK=0, RGB0/RGB1 <= 0, for BLANK_CYCLES cycles.
- LATCH: ROW <= row on entry. LATCH=1 for LATCH_CYCLES cycles. NOE stays 1.
- DISPLAY: lasts WIN_CYCLES cycles. brightness is captured on entry. NOE=0 for the first `brightness` cycles and 1 for the rest.
  - brightness=0 keeps NOE high for the whole window.
  - Changes to brightness mid-window are ignored.
- End of DISPLAY:
  - If row < 2**ROW_BITS-1: row++, col=0, enter SHIFT.
  - Otherwise: row wraps to 0 and frame_done=1 for one cycle. The next state is SHIFT if enable=1, else IDLE.
- Enable deassertion mid-frame: the frame completes, then the controller enters IDLE.
- Row period: COLS*(1+2*CLK_DIV)+BLANK_CYCLES+LATCH_CYCLES+WIN_CYCLES. With defaults this is 320+4+2+256 = 582 cycles, and a frame is 32*582 = 18624 cycles.
- Invariants:
  - LATCH and NOE=0 are never high/asserted together.
  - LP_CLK never toggles outside SHIFT.
  - ROW changes only on LATCH entry or reset.

Test Plan:
1. Reset state: assert rst mid-run at an arbitrary time -> all outputs take their reset values in the same time step; after release with enable=1, the first fb_addr is 0 (row 0, col 0).
2. Row shift: fb model returns addr[5:0] (so RGB0={addr[2:0]}, RGB1={addr[5:3]}); enable=1 -> exactly 64 LP_CLK rises in row 0; at rise k, {RGB1,RGB0}=k[5:0]; fb_rd pulses 64 times, once per 5-cycle slot.
3. Brightness: brightness=0 -> NOE never low for a full frame. brightness=128 -> NOE low exactly 128 consecutive cycles per row, starting the cycle after LATCH falls. brightness changed to 10 mid-window -> the current row still gets 128; the next row gets 10.
4. Scan order and wrap: enable held -> ROW sequence 0,1,...,31,0 at LATCH entries; frame_done pulses once every 18624 cycles; row period is 582 cycles.
5. Stop at boundary: drop enable during row 12 -> rows 13..31 still display; frame_done pulses; then IDLE with busy=0 and NOE=1; no further fb_rd.
6. Protocol checks (assertions across all runs): LATCH=1 implies NOE=1; no LP_CLK edge outside SHIFT; RGB0/RGB1 stable for CLK_DIV cycles before every LP_CLK rise.
